// File: rtl/link_seq_pkg.sv
// Shared types and helpers for the PSK link mode sequencer: state encoding,
// mode constants, request validation and error magnitude.
package link_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAIL    = 3'd4
    } link_state_t;

    localparam logic [3:0] MODE_BPSK = 4'b0001;
    localparam logic [3:0] MODE_QPSK = 4'b0010;
    localparam logic [3:0] MODE_MIX  = 4'b0100;

    // Only the defined one-hot modes are accepted; anything else is dropped.
    function automatic logic is_onehot_mode(input logic [3:0] mode);
        return (mode == MODE_BPSK) || (mode == MODE_QPSK) || (mode == MODE_MIX);
    endfunction

    // Two's-complement magnitude; the most negative code saturates to max positive.
    function automatic logic [15:0] abs_sat16(input logic [15:0] value);
        logic [15:0] mag;
        if (value == 16'h8000) begin
            mag = 16'h7FFF;
        end else if (value[15]) begin
            mag = 16'h0000 - value;
        end else begin
            mag = value;
        end
        return mag;
    endfunction

endpackage

// File: rtl/link_mode_sequencer_meter.sv
// Lock-window meter: counts symbol ticks per window and how many of them had a
// valid, small-enough phase error. Window totals are presented on the closing tick.
module lock_window_meter
    import link_seq_pkg::*;
#(
    parameter int          LOCK_WINDOW    = 256,
    parameter logic [15:0] LOCK_THRESHOLD = 16'd512
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         tick,
    input  logic                         rx_valid,
    input  logic [15:0]                  error_tdata,
    output logic                         win_done,
    output logic [$clog2(LOCK_WINDOW):0] good_cnt
);

    localparam int TW = $clog2(LOCK_WINDOW);
    localparam logic [TW-1:0] LAST_TICK = TW'(LOCK_WINDOW - 1);

    logic [TW-1:0] tick_cnt_r;
    logic [TW:0]   acc_r;
    logic          good_s;
    logic          last_s;

    assign good_s   = tick & rx_valid & (abs_sat16(error_tdata) < LOCK_THRESHOLD);
    assign last_s   = (tick_cnt_r == LAST_TICK);
    // Total includes the closing tick so the FSM can decide in the same cycle.
    assign good_cnt = acc_r + {{TW{1'b0}}, good_s};
    assign win_done = tick & last_s & ~clr;

    // Tick position and good-tick accumulator; windows restart back to back.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tick_cnt_r <= {TW{1'b0}};
            acc_r      <= {(TW + 1){1'b0}};
        end else if (tick) begin
            if (last_s) begin
                tick_cnt_r <= {TW{1'b0}};
                acc_r      <= {(TW + 1){1'b0}};
            end else begin
                tick_cnt_r <= tick_cnt_r + TW'(1'b1);
                acc_r      <= good_cnt;
            end
        end
    end

endmodule

// File: rtl/link_mode_sequencer.sv
// Link-level controller: owns MODE_CTRL and the datapath reset, sequences every
// mode change through reset, settle and lock acquisition, and reports lock/fail.
module link_mode_sequencer
    import link_seq_pkg::*;
#(
    parameter int          SETTLE_TICKS   = 64,
    parameter int          LOCK_WINDOW    = 256,
    parameter logic [15:0] LOCK_THRESHOLD = 16'd512,
    parameter int          MAX_RETRY      = 3,
    parameter int          RST_HOLD       = 16
) (
    input  logic        clk_32M768,
    input  logic        rst_32M768,
    input  logic        clk_1M024,
    input  logic [3:0]  mode_req,
    input  logic        mode_req_vld,
    output logic        mode_req_rdy,
    input  logic        rx_valid,
    input  logic [15:0] error_tdata,
    output logic [3:0]  MODE_CTRL,
    output logic        rst_n_datapath,
    output logic        link_locked,
    output logic        link_fail,
    output logic [2:0]  state_dbg
);

    localparam int GW = $clog2(LOCK_WINDOW) + 1;
    localparam int HW = $clog2(RST_HOLD + 1);
    localparam int SW = $clog2(SETTLE_TICKS + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [GW-1:0] PASS_LVL    = GW'(LOCK_WINDOW - LOCK_WINDOW / 8);
    localparam logic [GW-1:0] KEEP_LVL    = GW'(LOCK_WINDOW / 2);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(RST_HOLD - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_TICKS - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

    link_state_t   state_r, state_n_s;
    logic [HW-1:0] hold_cnt_r, hold_cnt_n_s;
    logic [SW-1:0] settle_cnt_r, settle_cnt_n_s;
    logic [RW-1:0] retry_r, retry_n_s;
    logic [3:0]    mode_r, mode_n_s;
    logic          clk_div_d_r, tick_r;
    logic          rst_n_dp_r, locked_r, fail_r, rdy_r;
    logic          take_req_s, win_done_s, meter_clr_s;
    logic [GW-1:0] good_cnt_s;

    // A valid mode request restarts the link, discarding any coincident tick.
    assign take_req_s  = mode_req_vld & rdy_r & is_onehot_mode(mode_req);
    assign meter_clr_s = ~((state_r == ST_ACQUIRE) | (state_r == ST_LOCKED)) | take_req_s;

    assign MODE_CTRL      = mode_r;
    assign rst_n_datapath = rst_n_dp_r;
    assign link_locked    = locked_r;
    assign link_fail      = fail_r;
    assign mode_req_rdy   = rdy_r;
    assign state_dbg      = state_r;

    // Symbol tick: registered rising-edge detect of the divided clock level.
    always_ff @(posedge clk_32M768) begin
        if (rst_32M768) begin
            clk_div_d_r <= 1'b0;
            tick_r      <= 1'b0;
        end else begin
            clk_div_d_r <= clk_1M024;
            tick_r      <= clk_1M024 & ~clk_div_d_r;
        end
    end

    lock_window_meter #(
        .LOCK_WINDOW    (LOCK_WINDOW),
        .LOCK_THRESHOLD (LOCK_THRESHOLD)
    ) u_meter (
        .clk         (clk_32M768),
        .rst         (rst_32M768),
        .clr         (meter_clr_s),
        .tick        (tick_r),
        .rx_valid    (rx_valid),
        .error_tdata (error_tdata),
        .win_done    (win_done_s),
        .good_cnt    (good_cnt_s)
    );

    // Next-state, counter and mode decisions.
    always_comb begin
        state_n_s      = state_r;
        hold_cnt_n_s   = {HW{1'b0}};
        settle_cnt_n_s = {SW{1'b0}};
        retry_n_s      = retry_r;
        mode_n_s       = mode_r;
        case (state_r)
            ST_RESET: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    state_n_s = ST_SETTLE;
                end else begin
                    hold_cnt_n_s = hold_cnt_r + HW'(1'b1);
                end
            end
            ST_SETTLE: begin
                if (tick_r && (settle_cnt_r == SETTLE_LAST)) begin
                    state_n_s = ST_ACQUIRE;
                end else if (tick_r) begin
                    settle_cnt_n_s = settle_cnt_r + SW'(1'b1);
                end else begin
                    settle_cnt_n_s = settle_cnt_r;
                end
            end
            ST_ACQUIRE: begin
                if (win_done_s && (good_cnt_s >= PASS_LVL)) begin
                    state_n_s = ST_LOCKED;
                    retry_n_s = {RW{1'b0}};
                end else if (win_done_s) begin
                    retry_n_s = retry_r + RW'(1'b1);
                    state_n_s = ((retry_r + RW'(1'b1)) == RETRY_MAX) ? ST_FAIL : ST_RESET;
                end else begin
                    state_n_s = ST_ACQUIRE;
                end
            end
            ST_LOCKED: begin
                if (take_req_s) begin
                    state_n_s = ST_RESET;
                    mode_n_s  = mode_req;
                    retry_n_s = {RW{1'b0}};
                end else if (win_done_s && (good_cnt_s < KEEP_LVL)) begin
                    state_n_s = ST_RESET;
                    retry_n_s = {RW{1'b0}};
                end else begin
                    state_n_s = ST_LOCKED;
                end
            end
            ST_FAIL: begin
                if (take_req_s) begin
                    state_n_s = ST_RESET;
                    mode_n_s  = mode_req;
                    retry_n_s = {RW{1'b0}};
                end else begin
                    state_n_s = ST_FAIL;
                end
            end
            default: begin
                state_n_s = ST_RESET;
            end
        endcase
    end

    // State, counters and registered outputs; outputs follow the next state.
    always_ff @(posedge clk_32M768) begin
        if (rst_32M768) begin
            state_r      <= ST_RESET;
            hold_cnt_r   <= {HW{1'b0}};
            settle_cnt_r <= {SW{1'b0}};
            retry_r      <= {RW{1'b0}};
            mode_r       <= MODE_BPSK;
            rst_n_dp_r   <= 1'b0;
            locked_r     <= 1'b0;
            fail_r       <= 1'b0;
            rdy_r        <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            hold_cnt_r   <= hold_cnt_n_s;
            settle_cnt_r <= settle_cnt_n_s;
            retry_r      <= retry_n_s;
            mode_r       <= mode_n_s;
            rst_n_dp_r   <= (state_n_s != ST_RESET);
            locked_r     <= (state_n_s == ST_LOCKED);
            fail_r       <= (state_n_s == ST_FAIL);
            rdy_r        <= (state_n_s == ST_LOCKED) || (state_n_s == ST_FAIL);
        end
    end

endmodule
